prog_loader: RTL

Loads a program image into the 16-word instruction memory of the pipelined processor. It receives a framed byte stream over a valid/ready handshake and packs byte pairs into 16-bit instruction words ([opcode][dest][src1][src2]). It writes those words sequentially through a single write port and holds the core until an image passes its checksum. It is the writer end of the instruction-memory path the core fetches from.

---
 rtl/prog_loader.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader: receives a framed byte stream (COUNT, N big-endian words, CSUM),
// packs byte pairs into 16-bit instruction words, writes them sequentially into
// the instruction memory and keeps the core held until a frame checks out.
module prog_loader #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_wdata;
  logic                r_hold;
  logic                r_done;
  logic                r_err;
  logic [ADDR_W:0]     r_words;
  logic [ADDR_W:0]     r_n;
  logic [7:0]          r_sum;
  logic [7:0]          r_hi;

  logic                w_in_ready;
  logic                w_cnt_ok;
  logic                w_more;
  logic [7:0]          w_sum_add;

  assign w_sum_add = r_sum + in_data;
  assign w_cnt_ok  = (in_data != 8'd0) && (32'(in_data) <= DEPTH);
  // All earlier words have already been counted by the time a lo byte
  // arrives, so this compares the word being accepted against N.
  assign w_more    = (r_words + (ADDR_W+1)'(1)) < r_n;

  assign in_ready     = w_in_ready;
  assign busy         = w_in_ready;
  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign core_hold    = r_hold;
  assign done         = r_done;
  assign error        = r_err;
  assign words_loaded = r_words;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and handshake decode; the stream is only accepted while loading.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) w_state_nxt = S_COUNT;
      end
      S_COUNT: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = w_cnt_ok ? S_HI : S_ERR;
      end
      S_HI: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_LO;
      end
      S_LO: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = w_more ? S_HI : S_CSUM;
      end
      S_CSUM: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = (w_sum_add == 8'd0) ? S_DONE : S_ERR;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: checksum, word packing, write pulse, address/count and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_words <= '0;
      r_n     <= '0;
      r_sum   <= '0;
      r_hi    <= '0;
    end else begin
      r_we <= 1'b0;
      // The address saturates at the top word so a full image never wraps to 0.
      if (r_we) begin
        r_words <= r_words + (ADDR_W+1)'(1);
        if (r_addr != '1) r_addr <= r_addr + ADDR_W'(1);
      end
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_words <= '0;
            r_addr  <= '0;
            r_sum   <= '0;
            r_hold  <= 1'b1;
          end
        end
        S_COUNT: begin
          if (in_valid) begin
            r_sum <= w_sum_add;
            if (w_cnt_ok) r_n   <= (ADDR_W+1)'(in_data);
            else          r_err <= 1'b1;
          end
        end
        S_HI: begin
          if (in_valid) begin
            r_sum <= w_sum_add;
            r_hi  <= in_data;
          end
        end
        S_LO: begin
          if (in_valid) begin
            r_sum   <= w_sum_add;
            r_we    <= 1'b1;
            r_wdata <= {r_hi, in_data};
          end
        end
        S_CSUM: begin
          if (in_valid) begin
            r_sum <= w_sum_add;
            if (w_sum_add == 8'd0) begin
              r_done <= 1'b1;
              r_hold <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
